// File: rtl/alu_logic_issuer.sv
// alu_logic_issuer
//   Decodes MIPS logical instructions (AND/OR/XOR/NOR/move) and issues them to an
//   external combinational logic unit, then returns the captured result through a
//   valid/ready response channel. One request is in flight at a time.
//
//   Optional feature macro: ALU_LOGIC_IMM_EN enables ANDI/ORI/XORI decoding
//   (opcodes 0x0C/0x0D/0x0E) with a zero-extended immediate as operand B.
//
// Ports
//   clk, rst_n            clock and synchronous active-low reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   instr, rs_val, rt_val instruction word and operand values
//   lu_ctrl, lu_a, lu_b   control code and operands to the logic unit
//   lu_dout               combinational logic-unit result
//   out_valid / out_ready response handshake
//   result, illegal       captured result and unsupported-instruction flag
//   ops_done              wrapping count of legal responses delivered
module alu_logic_issuer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [3:0]  lu_ctrl,
    output logic [31:0] lu_a,
    output logic [31:0] lu_b,
    input  logic [31:0] lu_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        illegal,
    output logic [15:0] ops_done
);

    localparam logic [3:0] CtrlAnd  = 4'b1000;
    localparam logic [3:0] CtrlOr   = 4'b1110;
    localparam logic [3:0] CtrlXor  = 4'b0110;
    localparam logic [3:0] CtrlNor  = 4'b0001;
    localparam logic [3:0] CtrlPass = 4'b1010;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic        illegal_q, illegal_d;
    logic [15:0] ops_done_q, ops_done_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_field;
    logic [15:0] imm;
    logic        dec_legal;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_b;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign rt_field = instr[20:16];
    assign imm      = instr[15:0];

    // rs and rd/shamt fields are not needed: operands arrive as values.
    logic unused_instr;
    assign unused_instr = ^{instr[25:21], instr[15:6]};

    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = CtrlPass;
        dec_b     = rt_val;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h24: begin dec_legal = 1'b1; dec_ctrl = CtrlAnd; end
                    6'h25: begin dec_legal = 1'b1; dec_ctrl = CtrlOr;  end
                    6'h26: begin dec_legal = 1'b1; dec_ctrl = CtrlXor; end
                    6'h27: begin dec_legal = 1'b1; dec_ctrl = CtrlNor; end
                    // addu rd, rs, $zero is the canonical move
                    6'h21: begin
                        if (rt_field == 5'd0) begin
                            dec_legal = 1'b1;
                            dec_ctrl  = CtrlPass;
                        end
                    end
                    default: ;
                endcase
            end
`ifdef ALU_LOGIC_IMM_EN
            6'h0C: begin dec_legal = 1'b1; dec_ctrl = CtrlAnd; dec_b = {16'b0, imm}; end
            6'h0D: begin dec_legal = 1'b1; dec_ctrl = CtrlOr;  dec_b = {16'b0, imm}; end
            6'h0E: begin dec_legal = 1'b1; dec_ctrl = CtrlXor; dec_b = {16'b0, imm}; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        illegal_d  = illegal_q;
        ops_done_d = ops_done_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    result_d = 32'd0;
                    if (dec_legal) begin
                        state_d   = StExec;
                        ctrl_d    = dec_ctrl;
                        a_d       = rs_val;
                        b_d       = dec_b;
                        illegal_d = 1'b0;
                    end else begin
                        // Unsupported ops skip the logic unit entirely.
                        state_d   = StResp;
                        illegal_d = 1'b1;
                    end
                end
            end
            StExec: begin
                result_d = lu_dout;
                state_d  = StResp;
            end
            StResp: begin
                if (out_ready) begin
                    state_d = StIdle;
                    if (!illegal_q) begin
                        ops_done_d = ops_done_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ctrl_q     <= CtrlPass;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            result_q   <= 32'd0;
            illegal_q  <= 1'b0;
            ops_done_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            illegal_q  <= illegal_d;
            ops_done_q <= ops_done_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StResp);
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign ops_done  = ops_done_q;

    // Logic unit sees the captured operation only while executing.
    always_comb begin
        lu_ctrl = CtrlPass;
        lu_a    = 32'd0;
        lu_b    = 32'd0;
        if (state_q == StExec) begin
            lu_ctrl = ctrl_q;
            lu_a    = a_q;
            lu_b    = b_q;
        end
    end

endmodule

// File: tb/tb_alu_logic_issuer.sv
module tb_alu_logic_issuer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [3:0]  lu_ctrl;
    logic [31:0] lu_a;
    logic [31:0] lu_b;
    logic [31:0] lu_dout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;
    logic [15:0] ops_done;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_ops;

    alu_logic_issuer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .lu_ctrl  (lu_ctrl),
        .lu_a     (lu_a),
        .lu_b     (lu_b),
        .lu_dout  (lu_dout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .illegal  (illegal),
        .ops_done (ops_done)
    );

    // External logic unit.
    always_comb begin
        case (lu_ctrl)
            4'b1000: lu_dout = lu_a & lu_b;
            4'b1110: lu_dout = lu_a | lu_b;
            4'b0110: lu_dout = lu_a ^ lu_b;
            4'b0001: lu_dout = ~(lu_a | lu_b);
            4'b1010: lu_dout = lu_a;
            default: lu_dout = 32'hDEAD_0000;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  ctrl;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    localparam int NVec = 11;
    vec_t vecs[NVec];

    function automatic logic [31:0] rtype(input logic [4:0] rt, input logic [5:0] fn);
        return {6'h00, 5'd4, rt, 5'd8, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] im);
        return {op, 5'd4, 5'd9, im};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one request with out_ready held high and check every phase.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        instr    = v.instr;
        rs_val   = v.rs;
        rt_val   = v.rt;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        instr    = 32'hFFFF_FFFF;
        rs_val   = 32'hA5A5_A5A5;
        rt_val   = 32'h5A5A_5A5A;
        if (!v.ill) begin
            check("exec_out_valid", {31'd0, out_valid}, 32'd0);
            check("exec_lu_ctrl", {28'd0, lu_ctrl}, {28'd0, v.ctrl});
            check("exec_lu_a", lu_a, v.rs);
            check("exec_lu_b", lu_b, v.b);
            @(negedge clk);
        end else begin
            check("ill_lu_ctrl", {28'd0, lu_ctrl}, 32'hA);
        end
        check("resp_out_valid", {31'd0, out_valid}, 32'd1);
        check("resp_in_ready", {31'd0, in_ready}, 32'd0);
        check("resp_result", result, v.res);
        check("resp_illegal", {31'd0, illegal}, {31'd0, v.ill});
        check("resp_lu_ctrl", {28'd0, lu_ctrl}, 32'hA);
        @(negedge clk);
        if (!v.ill) exp_ops = exp_ops + 16'd1;
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_ops_done", {16'd0, ops_done}, {16'd0, exp_ops});
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{rtype(5'd2, 6'h24), 32'hF0F0_1234, 32'h0FF0_FFFF, 4'b1000,
                     32'h0FF0_FFFF, 32'h00F0_1234, 1'b0};
        vecs[1]  = '{rtype(5'd2, 6'h25), 32'hF0F0_0000, 32'h0000_ABCD, 4'b1110,
                     32'h0000_ABCD, 32'hF0F0_ABCD, 1'b0};
        vecs[2]  = '{rtype(5'd2, 6'h26), 32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0110,
                     32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0};
        vecs[3]  = '{rtype(5'd2, 6'h27), 32'h0000_0000, 32'h0000_00FF, 4'b0001,
                     32'h0000_00FF, 32'hFFFF_FF00, 1'b0};
        vecs[4]  = '{rtype(5'd0, 6'h21), 32'hDEAD_BEEF, 32'h1234_5678, 4'b1010,
                     32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{rtype(5'd5, 6'h21), 32'h1111_1111, 32'h2222_2222, 4'b1010,
                     32'h0, 32'h0, 1'b1};
        vecs[6]  = '{itype(6'h23, 16'h0010), 32'h1111_1111, 32'h2222_2222, 4'b1010,
                     32'h0, 32'h0, 1'b1};
        vecs[7]  = '{rtype(5'd2, 6'h20), 32'h1111_1111, 32'h2222_2222, 4'b1010,
                     32'h0, 32'h0, 1'b1};
`ifdef ALU_LOGIC_IMM_EN
        vecs[8]  = '{itype(6'h0D, 16'h00AB), 32'h0000_1200, 32'hFFFF_FFFF, 4'b1110,
                     32'h0000_00AB, 32'h0000_12AB, 1'b0};
        vecs[9]  = '{itype(6'h0C, 16'hF0F0), 32'h1234_5678, 32'hFFFF_FFFF, 4'b1000,
                     32'h0000_F0F0, 32'h0000_5070, 1'b0};
        vecs[10] = '{itype(6'h0E, 16'hFFFF), 32'h1234_5678, 32'h0000_0000, 4'b0110,
                     32'h0000_FFFF, 32'h1234_A987, 1'b0};
`else
        vecs[8]  = '{itype(6'h0D, 16'h00AB), 32'h0000_1200, 32'hFFFF_FFFF, 4'b1010,
                     32'h0, 32'h0, 1'b1};
        vecs[9]  = '{itype(6'h0C, 16'hF0F0), 32'h1234_5678, 32'hFFFF_FFFF, 4'b1010,
                     32'h0, 32'h0, 1'b1};
        vecs[10] = '{itype(6'h0E, 16'hFFFF), 32'h1234_5678, 32'h0000_0000, 4'b1010,
                     32'h0, 32'h0, 1'b1};
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'd0;
        rs_val    = 32'd0;
        rt_val    = 32'd0;
        exp_ops   = 16'd0;

        // Reset state after the first reset edge.
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_ops_done", {16'd0, ops_done}, 32'd0);
        check("rst_lu_ctrl", {28'd0, lu_ctrl}, 32'hA);
        check("rst_lu_a", lu_a, 32'd0);
        check("rst_lu_b", lu_b, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVec; i++) run_vec(vecs[i]);

        // NOR under backpressure; a competing request must be ignored.
        @(negedge clk);
        instr = rtype(5'd2, 6'h27); rs_val = 32'd0; rt_val = 32'h0000_00FF;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        instr = rtype(5'd2, 6'h24); rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", result, 32'hFFFF_FF00);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        exp_ops = exp_ops + 16'd1;
        // in_valid still high: handshake cycle must not accept it.
        check("bp_post_valid", {31'd0, out_valid}, 32'd0);
        check("bp_post_ready", {31'd0, in_ready}, 32'd1);
        check("bp_post_ops", {16'd0, ops_done}, {16'd0, exp_ops});
        check("bp_post_lu_ctrl", {28'd0, lu_ctrl}, 32'hA);
        in_valid = 1'b0;
        out_ready = 1'b0;

        // Reset while a response is pending.
        @(negedge clk);
        instr = rtype(5'd2, 6'h25); rs_val = 32'h1; rt_val = 32'h2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mr_out_valid_pre", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 16'd0;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_ops_done", {16'd0, ops_done}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        check("mr_result", result, 32'd0);

        // Counter wrap: preload near the top, then two legal ops.
        @(negedge clk);
        force dut.ops_done_q = 16'hFFFE;
        #1;
        release dut.ops_done_q;
        exp_ops = 16'hFFFE;
        run_vec(vecs[0]);
        run_vec(vecs[3]);
        check("wrap_ops_done", {16'd0, ops_done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
